// File: rtl/lieat_ifu_realign.sv
// lieat_ifu_realign
// Halfword realigner between the fetch-word FIFO and decode. Consumes
// word-aligned 32-bit fetch words and emits one RVC or 32-bit instruction
// per handshake. It keeps a single 16-bit carry buffer for a leftover upper
// half, which may be a whole RVC instruction or the first half of a 32-bit
// instruction that straddles two words. A redirect flush restarts alignment
// at any halfword PC. All outputs are combinational from the registered
// state and the current input word, so there is no added latency.

module lieat_ifu_realign #(
   parameter int PCW  = 32,
   parameter bit MASK = 1'b1
) (
   input  logic           clk,
   input  logic           rstn,
   // fetch-word side
   input  logic           i_valid,
   output logic           i_ready,
   input  logic [31:0]    i_data,
   input  logic [PCW-1:0] i_pc,
   // decode side
   output logic           o_valid,
   input  logic           o_ready,
   output logic [31:0]    o_instr,
   output logic [PCW-1:0] o_pc,
   output logic           o_rvc,
   // redirect
   input  logic           flush,
   input  logic [PCW-1:0] flush_pc
);

   // Operating mode for the current cycle, decoded in priority order.
   typedef enum logic [2:0] {
      M_FLUSH,
      M_SKIP,
      M_CARRY16,
      M_CARRY32,
      M_ALIGN16,
      M_ALIGN32
   } mode_t;

   // Registered state
   logic           lo_vld;
   logic [15:0]    lo_data;
   logic [PCW-1:0] lo_pc;
   logic           skip;

   // Next-state values
   logic           lo_vld_nxt;
   logic [15:0]    lo_data_nxt;
   logic [PCW-1:0] lo_pc_nxt;
   logic           skip_nxt;

   // Unmasked output values
   logic           out_vld;
   logic [31:0]    out_instr;
   logic [PCW-1:0] out_pc;
   logic           out_rvc;

   mode_t          mode;

   // A halfword whose two low bits are both set opens a 32-bit instruction.
   logic lo_is_32;
   logic in_is_32;
   assign lo_is_32 = (lo_data[1:0] == 2'b11);
   assign in_is_32 = (i_data[1:0] == 2'b11);

   // PC of the upper halfword of the incoming word, and the word's own PC.
   logic [PCW-1:0] in_hi_pc;
   logic [PCW-1:0] in_lo_pc;
   assign in_hi_pc = {i_pc[PCW-1:2], 2'b10};
   assign in_lo_pc = {i_pc[PCW-1:2], 2'b00};

   // Word-address bits of flush_pc and the low PC bits are not needed: the
   // upstream FIFO restarts at the same word, and only the halfword select
   // of the redirect target matters here.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{i_pc[1:0], flush_pc[PCW-1:2], flush_pc[0]};

   // Mode decode: flush beats skip beats the carry buffer beats aligned.
   always_comb begin
      if (flush) begin
         mode = M_FLUSH;
      end else if (skip) begin
         mode = M_SKIP;
      end else if (lo_vld) begin
         mode = lo_is_32 ? M_CARRY32 : M_CARRY16;
      end else begin
         mode = in_is_32 ? M_ALIGN32 : M_ALIGN16;
      end
   end

   // Datapath and next-state selection for each mode.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one
      // unassigned; a missing default here would infer a latch.
      out_vld     = 1'b0;
      out_instr   = 32'h0;
      out_pc      = '0;
      out_rvc     = 1'b0;
      i_ready     = 1'b0;
      lo_vld_nxt  = lo_vld;
      lo_data_nxt = lo_data;
      lo_pc_nxt   = lo_pc;
      skip_nxt    = skip;

      unique case (mode)
         M_FLUSH: begin
            // Drop any buffered half; if the target is an upper halfword
            // the lower half of the first refetched word must be discarded.
            lo_vld_nxt = 1'b0;
            skip_nxt   = flush_pc[1];
         end

         M_SKIP: begin
            // Swallow the word unconditionally and keep only its upper half.
            i_ready = 1'b1;
            if (i_valid) begin
               lo_data_nxt = i_data[31:16];
               lo_pc_nxt   = in_hi_pc;
               lo_vld_nxt  = 1'b1;
               skip_nxt    = 1'b0;
            end
         end

         M_CARRY16: begin
            // Buffered RVC instruction goes out without touching the input.
            out_vld   = 1'b1;
            out_instr = {16'h0, lo_data};
            out_pc    = lo_pc;
            out_rvc   = 1'b1;
            if (o_ready) begin
               lo_vld_nxt = 1'b0;
            end
         end

         M_CARRY32: begin
            // Straddling instruction: buffered low half plus the new word's
            // low half; the new upper half replaces the buffer.
            out_vld   = i_valid;
            out_instr = {i_data[15:0], lo_data};
            out_pc    = lo_pc;
            out_rvc   = 1'b0;
            i_ready   = o_ready;
            if (i_valid && o_ready) begin
               lo_data_nxt = i_data[31:16];
               lo_pc_nxt   = in_hi_pc;
            end
         end

         M_ALIGN16: begin
            // Lower half is RVC; park the upper half in the buffer.
            out_vld   = i_valid;
            out_instr = {16'h0, i_data[15:0]};
            out_pc    = in_lo_pc;
            out_rvc   = 1'b1;
            i_ready   = o_ready;
            if (i_valid && o_ready) begin
               lo_data_nxt = i_data[31:16];
               lo_pc_nxt   = in_hi_pc;
               lo_vld_nxt  = 1'b1;
            end
         end

         M_ALIGN32: begin
            // Whole word is one aligned 32-bit instruction; buffer unused.
            out_vld   = i_valid;
            out_instr = i_data;
            out_pc    = in_lo_pc;
            out_rvc   = 1'b0;
            i_ready   = o_ready;
         end

         default: begin
         end
      endcase
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         // NOTE: lo_data and lo_pc are reset too, even though lo_vld alone
         // qualifies them, so the block leaves reset in a fully known state.
         lo_vld  <= 1'b0;
         lo_data <= 16'h0;
         lo_pc   <= '0;
         skip    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values computed above, independent of statement order.
         lo_vld  <= lo_vld_nxt;
         lo_data <= lo_data_nxt;
         lo_pc   <= lo_pc_nxt;
         skip    <= skip_nxt;
      end
   end

   // Optional gating of the payload so idle cycles present all-zero fields.
   assign o_valid = out_vld;
   generate
      if (MASK) begin : g_mask
         assign o_instr = out_instr & {32{out_vld}};
         assign o_pc    = out_pc & {PCW{out_vld}};
         assign o_rvc   = out_rvc & out_vld;
      end else begin : g_nomask
         assign o_instr = out_instr;
         assign o_pc    = out_pc;
         assign o_rvc   = out_rvc;
      end
   endgenerate

endmodule

// File: tb/tb_lieat_ifu_realign.sv
// Testbench for lieat_ifu_realign: directed scenarios followed by random
// flush-delimited fetch streams. The reference model treats each stream as
// a flat list of halfwords starting at the redirect PC and parses it into
// instructions by the length rule; a monitor pops that list on every
// output handshake.

module tb_lieat_ifu_realign;

   logic        clk;
   logic        rstn;
   logic        i_valid;
   logic        i_ready;
   logic [31:0] i_data;
   logic [31:0] i_pc;
   logic        o_valid;
   logic        o_ready;
   logic [31:0] o_instr;
   logic [31:0] o_pc;
   logic        o_rvc;
   logic        flush;
   logic [31:0] flush_pc;

   int checks = 0;
   int errors = 0;
   bit sb_on  = 1'b0;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        rvc;
   } exp_t;

   exp_t sbq[$];

   lieat_ifu_realign #(.PCW(32), .MASK(1'b1)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .i_valid  (i_valid),
      .i_ready  (i_ready),
      .i_data   (i_data),
      .i_pc     (i_pc),
      .o_valid  (o_valid),
      .o_ready  (o_ready),
      .o_instr  (o_instr),
      .o_pc     (o_pc),
      .o_rvc    (o_rvc),
      .flush    (flush),
      .flush_pc (flush_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Check all outputs at the negative edge, then step past the next rising
   // edge. Idle cycles expect zeroed payload because the outputs are masked.
   task automatic cyc_check(string t, logic ev, logic [31:0] ei, logic [31:0] ep,
                            logic er, logic eir);
      @(negedge clk);
      check({t, ".o_valid"}, o_valid, ev);
      check({t, ".o_instr"}, o_instr, ev ? ei : 32'h0);
      check({t, ".o_pc"},    o_pc,    ev ? ep : 32'h0);
      check({t, ".o_rvc"},   o_rvc,   ev ? er : 1'b0);
      check({t, ".i_ready"}, i_ready, eir);
      @(posedge clk);
      #1;
   endtask

   task automatic set_word(logic v, logic [31:0] d, logic [31:0] pc);
      i_valid = v;
      i_data  = d;
      i_pc    = pc;
   endtask

   function automatic logic [15:0] rnd_hw();
      logic [15:0] h;
      h = 16'($urandom);
      if ($urandom_range(1, 0) == 1) h[1:0] = 2'b11;
      else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
      return h;
   endfunction

   // Scoreboard monitor: every accepted instruction must match the head of
   // the expected list.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_on && o_valid && o_ready) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb.unexpected: got instr %h pc %h rvc %0b, expected nothing",
                        o_instr, o_pc, o_rvc);
            end else begin
               e = sbq.pop_front();
               check("sb.instr", o_instr, e.instr);
               check("sb.pc",    o_pc,    e.pc);
               check("sb.rvc",   o_rvc,   e.rvc);
            end
         end
      end
   end

   initial begin
      rstn = 1'b0; flush = 1'b0; flush_pc = 32'h0; o_ready = 1'b1;
      set_word(1'b0, 32'h0, 32'h0);

      // Reset: idle input gives no output, i_ready follows o_ready.
      @(negedge clk);
      check("rst.o_valid", o_valid, 1'b0);
      check("rst.i_ready", i_ready, 1'b1);
      check("rst.o_instr", o_instr, 32'h0);
      o_ready = 1'b0;
      #1 check("rst.i_ready_follow", i_ready, 1'b0);
      set_word(1'b1, 32'h00000013, 32'h0);
      #1 check("rst.o_valid_follow", o_valid, 1'b1);
      set_word(1'b0, 32'h0, 32'h0);
      o_ready = 1'b1;
      @(posedge clk);
      #1 rstn = 1'b1;

      // Aligned 32-bit word.
      set_word(1'b1, 32'h00000013, 32'h80000000);
      cyc_check("aligned32", 1, 32'h00000013, 32'h80000000, 0, 1);

      // Two RVC instructions in one word.
      set_word(1'b1, 32'h45014505, 32'h00001000);
      cyc_check("rvc2.a", 1, 32'h00004505, 32'h00001000, 1, 1);
      set_word(1'b0, 32'h0, 32'h0);
      cyc_check("rvc2.b", 1, 32'h00004501, 32'h00001002, 1, 0);
      cyc_check("rvc2.idle", 0, 0, 0, 0, 1);

      // RVC, straddling 32-bit, RVC on consecutive cycles.
      set_word(1'b1, 32'h00134505, 32'h00001000);
      cyc_check("strad.a", 1, 32'h00004505, 32'h00001000, 1, 1);
      set_word(1'b1, 32'h45010000, 32'h00001004);
      cyc_check("strad.b", 1, 32'h00000013, 32'h00001002, 0, 1);
      set_word(1'b0, 32'h0, 32'h0);
      cyc_check("strad.c", 1, 32'h00004501, 32'h00001006, 1, 0);

      // Flush to an upper halfword: one skip bubble then the upper RVC.
      flush = 1'b1; flush_pc = 32'h00002002;
      set_word(1'b1, 32'hDEADBEEF, 32'h00009000);
      cyc_check("flush.cyc", 0, 0, 0, 0, 0);
      flush = 1'b0;
      o_ready = 1'b0;
      set_word(1'b1, 32'h00010001, 32'h00002000);
      cyc_check("skip.cyc", 0, 0, 0, 0, 1);
      o_ready = 1'b1;
      set_word(1'b0, 32'h0, 32'h0);
      cyc_check("skip.out", 1, 32'h00000001, 32'h00002002, 1, 0);

      // CARRY32 stalled by decode, then flushed away.
      set_word(1'b1, 32'h00134505, 32'h00003000);
      cyc_check("stall.pre", 1, 32'h00004505, 32'h00003000, 1, 1);
      o_ready = 1'b0;
      set_word(1'b1, 32'hBEEFA5A7, 32'h00003004);
      for (int k = 0; k < 3; k++)
         cyc_check($sformatf("stall.%0d", k), 1, 32'hA5A70013, 32'h00003002, 0, 0);
      flush = 1'b1; flush_pc = 32'h00004000;
      cyc_check("stall.flush", 0, 0, 0, 0, 0);
      flush = 1'b0; o_ready = 1'b1;
      set_word(1'b1, 32'h00000013, 32'h00004000);
      cyc_check("stall.after", 1, 32'h00000013, 32'h00004000, 0, 1);

      // Asynchronous reset mid-straddle discards the buffered half.
      set_word(1'b1, 32'h00134505, 32'h00005000);
      cyc_check("rstmid.pre", 1, 32'h00004505, 32'h00005000, 1, 1);
      rstn = 1'b0;
      set_word(1'b1, 32'h00000013, 32'h00006000);
      cyc_check("rstmid.held", 1, 32'h00000013, 32'h00006000, 0, 1);
      rstn = 1'b1;
      cyc_check("rstmid.after", 1, 32'h00000013, 32'h00006000, 0, 1);

      // Random flush-delimited streams checked by the scoreboard.
      set_word(1'b0, 32'h0, 32'h0);
      sb_on = 1'b1;
      for (int seg = 0; seg < 80; seg++) begin
         logic [31:0] fpc;
         logic [31:0] base;
         logic [31:0] w;
         logic [31:0] words[$];
         logic [15:0] hw[$];
         int          n;
         int          s;
         int          budget;
         bit          done;

         fpc = {$urandom} & 32'hFFFFFFFE;
         if (seg % 8 == 0) fpc = 32'hFFFFFFF8 | ($urandom_range(7, 0) & 32'h6);
         base = fpc & 32'hFFFFFFFC;
         n = $urandom_range(6, 1);
         words.delete();
         hw.delete();
         for (int k = 0; k < n; k++) begin
            w = {rnd_hw(), rnd_hw()};
            words.push_back(w);
            hw.push_back(w[15:0]);
            hw.push_back(w[31:16]);
         end

         // Parse the halfword stream from the redirect target.
         s = int'(fpc[1]);
         while (s < 2 * n) begin
            if (hw[s][1:0] == 2'b11) begin
               if (s + 1 >= 2 * n) break;
               sbq.push_back('{instr: {hw[s+1], hw[s]}, pc: base + 32'(2 * s), rvc: 1'b0});
               s += 2;
            end else begin
               sbq.push_back('{instr: {16'h0, hw[s]}, pc: base + 32'(2 * s), rvc: 1'b1});
               s += 1;
            end
         end

         // Redirect cycle with junk on the inputs.
         flush = 1'b1; flush_pc = fpc;
         set_word(1'($urandom), $urandom, $urandom);
         o_ready = 1'($urandom);
         @(negedge clk);
         check("rnd.flush_o_valid", o_valid, 1'b0);
         @(posedge clk);
         #1 flush = 1'b0;

         for (int k = 0; k < n; k++) begin
            budget = 0;
            done = 1'b0;
            while (!done) begin
               set_word($urandom_range(3, 0) != 0, words[k],
                        (base + 32'(4 * k)) | 32'($urandom_range(3, 0)));
               o_ready = ($urandom_range(9, 0) < 7);
               @(negedge clk);
               if (i_valid && i_ready) done = 1'b1;
               @(posedge clk);
               #1;
               budget++;
               if (!done && budget > 200) begin
                  checks++;
                  errors++;
                  $display("FAIL rnd.consume_timeout: word %0d of segment %0d not taken", k, seg);
                  done = 1'b1;
               end
            end
         end

         // Drain any buffered RVC instruction before the next redirect.
         set_word(1'b0, 32'h0, 32'h0);
         budget = 0;
         while (sbq.size() > 0 && budget < 100) begin
            o_ready = ($urandom_range(9, 0) < 7);
            @(posedge clk);
            #1;
            budget++;
         end
         if (sbq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL rnd.drain_timeout: %0d expected instructions left, required 0",
                     sbq.size());
            sbq.delete();
         end
      end
      sb_on = 1'b0;
      check("sb.empty", sbq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
